// File: rtl/seg7_pkg.sv
// Shared display types, constants and the 7-segment glyph decoder.
// Glyphs are active-low, bit order [6:0] = g f e d c b a.
package seg7_pkg;

   typedef logic [3:0] digit_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ZERO  = 8'hC0;

   function automatic logic [6:0] seg7_decode(input digit_t d);
      logic [6:0] s;
      s = SEG_BLANK[6:0];
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = SEG_BLANK[6:0];
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Divide-by-DIV pulse generator with hold (run=0) and synchronous clear.
// Ports: clk, reset (sync, high), run, clear -> pulse (registered, 1 cycle).
module tick_gen #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic pulse
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   // Pulse lands in the cycle after the counter sits on LAST.
   always_comb begin
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q == LAST) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/updown_sevenseg_counter.sv
// Multi-digit BCD/hex up/down counter with muxed common-anode 7-seg drive.
// In: clk, reset, direction, enable, load, load_value. Out: count, tick,
// at_limit, segment (active-low, [7]=dp), anode (active-low one-hot).
module updown_sevenseg_counter
   import seg7_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned TICK_HZ    = 1,
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned REFRESH_HZ = 1000,
   parameter int unsigned HEX_MODE   = 0,
   parameter int unsigned WRAP       = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    direction,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    tick,
   output logic                    at_limit,
   output logic [7:0]              segment,
   output logic [NUM_DIGITS-1:0]   anode
);

   localparam int unsigned W        = 4 * NUM_DIGITS;
   localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned DWELL    = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int unsigned IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [W-1:0] UP_LIM  = (HEX_MODE != 0) ?
                                      {NUM_DIGITS{4'hF}} : {NUM_DIGITS{4'h9}};
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   if (TICK_DIV < 2) begin : g_bad_tick
      $error("tick period CLK_HZ/TICK_HZ must be at least 2 cycles");
   end
   if (DWELL < 1) begin : g_bad_dwell
      $error("digit dwell CLK_HZ/(REFRESH_HZ*NUM_DIGITS) must be >= 1");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("NUM_DIGITS must be in 1..8");
   end

   logic step_w;
   logic scan_w;

   tick_gen #(.DIV(TICK_DIV)) u_prescale (
      .clk   (clk),
      .reset (reset),
      .run   (enable),
      .clear (load),
      .pulse (step_w)
   );

   tick_gen #(.DIV(DWELL)) u_refresh (
      .clk   (clk),
      .reset (reset),
      .run   (1'b1),
      .clear (1'b0),
      .pulse (scan_w)
   );

   logic [W-1:0]          count_q, count_d;
   logic [W-1:0]          stepped;
   logic [W-1:0]          ld_clamped;
   logic                  at_end;
   logic                  at_limit_q, at_limit_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [7:0]            segment_q, segment_d;
   logic                  carry;
   digit_t                dig;
   digit_t                cur_dig;

   // One step in the sampled direction; BCD ripples carry/borrow per digit.
   always_comb begin
      stepped = count_q;
      carry   = 1'b1;
      dig     = '0;
      if (HEX_MODE != 0) begin
         stepped = direction ? count_q + W'(1) : count_q - W'(1);
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
               if (direction) begin
                  if (dig == 4'd9) begin
                     stepped[4*i +: 4] = 4'd0;
                  end else begin
                     stepped[4*i +: 4] = dig + 4'd1;
                     carry = 1'b0;
                  end
               end else begin
                  if (dig == 4'd0) begin
                     stepped[4*i +: 4] = 4'd9;
                  end else begin
                     stepped[4*i +: 4] = dig - 4'd1;
                     carry = 1'b0;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      ld_clamped = load_value;
      if (HEX_MODE == 0) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
               ld_clamped[4*i +: 4] = 4'd9;
            end
         end
      end
   end

   assign at_end = direction ? (count_q == UP_LIM) : (count_q == '0);

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = ld_clamped;
      end else if (step_w) begin
         if (WRAP == 0 && at_end) begin
            count_d = count_q;
         end else begin
            count_d = stepped;
         end
      end
      at_limit_d = direction ? (count_d == UP_LIM) : (count_d == '0);
   end

   // Anode and glyph both come from idx_q so they switch on the same edge.
   always_comb begin
      idx_d = idx_q;
      if (scan_w) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end
      cur_dig   = count_q[4*int'(idx_q) +: 4];
      anode_d   = ~(NUM_DIGITS'(1) << idx_q);
      segment_d = {~((idx_q == '0) && direction), seg7_decode(cur_dig)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         at_limit_q <= ~direction;
         idx_q      <= '0;
         anode_q    <= ~(NUM_DIGITS'(1));
         segment_q  <= SEG_ZERO;
      end else begin
         count_q    <= count_d;
         at_limit_q <= at_limit_d;
         idx_q      <= idx_d;
         anode_q    <= anode_d;
         segment_q  <= segment_d;
      end
   end

   assign count    = count_q;
   assign tick     = step_w;
   assign at_limit = at_limit_q;
   assign anode    = anode_q;
   assign segment  = segment_q;

endmodule

// File: tb/tb_updown_sevenseg_counter.sv
// Three configurations (BCD wrap, BCD saturate, hex wrap) on shared stimulus,
// checked every cycle against a decimal/integer model plus literal checks.
module tb_updown_sevenseg_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       direction = 1'b0;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_value = 8'h00;

   logic [7:0] cnt0, cnt1, cnt2;
   logic       tk0, tk1, tk2;
   logic       lim0, lim1, lim2;
   logic [7:0] seg0, seg1, seg2;
   logic [1:0] an0, an1, an2;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   updown_sevenseg_counter #(
      .CLK_HZ(100), .TICK_HZ(10), .NUM_DIGITS(2), .REFRESH_HZ(10),
      .HEX_MODE(0), .WRAP(1)
   ) dut_bw (
      .clk(clk), .reset(reset), .direction(direction), .enable(enable),
      .load(load), .load_value(load_value), .count(cnt0), .tick(tk0),
      .at_limit(lim0), .segment(seg0), .anode(an0)
   );

   updown_sevenseg_counter #(
      .CLK_HZ(100), .TICK_HZ(10), .NUM_DIGITS(2), .REFRESH_HZ(10),
      .HEX_MODE(0), .WRAP(0)
   ) dut_bs (
      .clk(clk), .reset(reset), .direction(direction), .enable(enable),
      .load(load), .load_value(load_value), .count(cnt1), .tick(tk1),
      .at_limit(lim1), .segment(seg1), .anode(an1)
   );

   updown_sevenseg_counter #(
      .CLK_HZ(100), .TICK_HZ(10), .NUM_DIGITS(2), .REFRESH_HZ(10),
      .HEX_MODE(1), .WRAP(1)
   ) dut_hx (
      .clk(clk), .reset(reset), .direction(direction), .enable(enable),
      .load(load), .load_value(load_value), .count(cnt2), .tick(tk2),
      .at_limit(lim2), .segment(seg2), .anode(an2)
   );

   // ---------------- model ----------------
   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                              7'h46, 7'h21, 7'h06, 7'h0E};
   int  MAXV [3] = '{99, 99, 255};
   bit  WRP  [3] = '{1'b1, 1'b0, 1'b1};
   bit  HX   [3] = '{1'b0, 1'b0, 1'b1};

   int         m_v   [3];
   logic       m_lim [3];
   logic [7:0] m_seg [3];
   logic [1:0] m_an;
   logic       m_tk;
   int         m_ph, m_r, m_idx;
   logic       m_rp;

   function automatic logic [7:0] packv(int c, int v);
      if (HX[c]) return 8'(v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic int ldval(int c, logic [7:0] lv);
      int hi, lo;
      if (HX[c]) return int'(lv);
      hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
      lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
      return hi * 10 + lo;
   endfunction

   function automatic int stepv(int c, int v, logic up);
      if (up) begin
         if (v == MAXV[c]) return WRP[c] ? 0 : MAXV[c];
         return v + 1;
      end
      if (v == 0) return WRP[c] ? MAXV[c] : 0;
      return v - 1;
   endfunction

   always @(posedge clk) begin
      logic [7:0] p;
      logic       nt;
      if (reset) begin
         m_ph = 0; m_tk = 1'b0; m_r = 0; m_rp = 1'b0; m_idx = 0;
         m_an = 2'b10;
         for (int c = 0; c < 3; c++) begin
            m_v[c]   = 0;
            m_lim[c] = ~direction;
            m_seg[c] = 8'hC0;
         end
      end else begin
         for (int c = 0; c < 3; c++) begin
            p = packv(c, m_v[c]);
            m_seg[c] = {~(m_idx == 0 && direction),
                        glyph[(m_idx == 0) ? p[3:0] : p[7:4]]};
         end
         m_an = (m_idx == 0) ? 2'b10 : 2'b01;
         for (int c = 0; c < 3; c++) begin
            if (load) m_v[c] = ldval(c, load_value);
            else if (m_tk) m_v[c] = stepv(c, m_v[c], direction);
            m_lim[c] = direction ? (m_v[c] == MAXV[c]) : (m_v[c] == 0);
         end
         nt = 1'b0;
         if (load) m_ph = 0;
         else if (enable) begin
            if (m_ph == 9) begin m_ph = 0; nt = 1'b1; end
            else m_ph = m_ph + 1;
         end
         m_tk = nt;
         if (m_rp) m_idx = (m_idx + 1) % 2;
         if (m_r == 4) begin m_r = 0; m_rp = 1'b1; end
         else begin m_r = m_r + 1; m_rp = 1'b0; end
      end
   end

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("bw.count", cnt0, packv(0, m_v[0]));
         chk("bs.count", cnt1, packv(1, m_v[1]));
         chk("hx.count", cnt2, packv(2, m_v[2]));
         chk("bw.lim", 8'(lim0), 8'(m_lim[0]));
         chk("bs.lim", 8'(lim1), 8'(m_lim[1]));
         chk("hx.lim", 8'(lim2), 8'(m_lim[2]));
         chk("bw.tick", 8'(tk0), 8'(m_tk));
         chk("bs.tick", 8'(tk1), 8'(m_tk));
         chk("hx.tick", 8'(tk2), 8'(m_tk));
         chk("bw.seg", seg0, m_seg[0]);
         chk("bs.seg", seg1, m_seg[1]);
         chk("hx.seg", seg2, m_seg[2]);
         chk("bw.an", 8'(an0), 8'(m_an));
         chk("bs.an", 8'(an1), 8'(m_an));
         chk("hx.an", 8'(an2), 8'(m_an));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 20 && tk0 !== 1'b1; i++) cyc(1);
      chk("wait_tick", 8'(tk0), 8'h01);
   endtask

   initial begin
      int ticks;
      @(posedge clk);
      cmp_on = 1'b1;
      #1;
      cyc(7);
      // 1: reset state and first digit switch
      chk("rst.count", cnt0, 8'h00);
      chk("rst.tick", 8'(tk0), 8'h00);
      chk("rst.anode", 8'(an0), 8'h02);
      chk("rst.seg", seg0, 8'hC0);
      chk("rst.lim", 8'(lim0), 8'h01);
      reset = 1'b0;
      cyc(6);
      chk("scan.an0", 8'(an0), 8'h02);
      cyc(1);
      chk("scan.an1", 8'(an0), 8'h01);
      chk("scan.seg1", seg0, 8'hC0);

      // 2: BCD wrap up through 99
      load = 1'b1; load_value = 8'h98; direction = 1'b1; enable = 1'b1;
      cyc(1);
      load = 1'b0;
      chk("t2.load", cnt0, 8'h98);
      wait_tick();
      cyc(1);
      chk("t2.99", cnt0, 8'h99);
      chk("t2.lim", 8'(lim0), 8'h01);
      wait_tick();
      cyc(1);
      chk("t2.wrap", cnt0, 8'h00);
      chk("t2.sat", cnt1, 8'h99);
      chk("t2.hex", cnt2, 8'h9A);

      // 3: count down from 00 for 30 enabled cycles
      load = 1'b1; load_value = 8'h00; direction = 1'b0; enable = 1'b0;
      cyc(1);
      load = 1'b0; enable = 1'b1;
      ticks = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (tk1 === 1'b1) ticks++;
      end
      chk("t3.ticks", 8'(ticks), 8'd3);
      chk("t3.sat", cnt1, 8'h00);
      chk("t3.satlim", 8'(lim1), 8'h01);
      chk("t3.wrap", cnt0, 8'h98);
      chk("t3.hex", cnt2, 8'hFE);

      // 4: hex carry and glyph F
      load = 1'b1; load_value = 8'h0F; direction = 1'b1; enable = 1'b1;
      cyc(1);
      load = 1'b0;
      wait_tick();
      cyc(1);
      chk("t4.hex", cnt2, 8'h10);
      chk("t4.bcd", cnt0, 8'h10);
      load = 1'b1; load_value = 8'h0F; enable = 1'b0;
      cyc(1);
      load = 1'b0;
      cyc(1);
      for (int i = 0; i < 12 && an2 !== 2'b10; i++) cyc(1);
      chk("t4.an", 8'(an2), 8'h02);
      chk("t4.segF", seg2, 8'h0E);
      chk("t4.seg9", seg0, 8'h10);

      // 5: load on a tick cycle, then BCD clamp
      enable = 1'b1;
      wait_tick();
      load = 1'b1; load_value = 8'h42;
      cyc(1);
      load = 1'b0;
      chk("t5.load", cnt0, 8'h42);
      chk("t5.hexld", cnt2, 8'h42);
      chk("t5.notick", 8'(tk0), 8'h00);
      cyc(9);
      chk("t5.early", 8'(tk0), 8'h00);
      chk("t5.hold", cnt0, 8'h42);
      cyc(1);
      chk("t5.tick", 8'(tk0), 8'h01);
      cyc(1);
      chk("t5.step", cnt0, 8'h43);
      load = 1'b1; load_value = 8'hAC;
      cyc(1);
      load = 1'b0;
      chk("t5.clamp", cnt0, 8'h99);
      chk("t5.hexAC", cnt2, 8'hAC);

      // 6: freeze mid-period, resume, reset beats load
      cyc(4);
      enable = 1'b0;
      ticks = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1);
         if (tk0 === 1'b1) ticks++;
      end
      chk("t6.noticks", 8'(ticks), 8'd0);
      chk("t6.frozen", cnt2, 8'hAC);
      enable = 1'b1;
      cyc(5);
      chk("t6.pre", 8'(tk0), 8'h00);
      cyc(1);
      chk("t6.resume", 8'(tk0), 8'h01);
      reset = 1'b1; load = 1'b1; load_value = 8'h55;
      cyc(1);
      chk("t6.rst", cnt0, 8'h00);
      chk("t6.rsthx", cnt2, 8'h00);
      chk("t6.rstan", 8'(an0), 8'h02);
      reset = 1'b0; load = 1'b0; enable = 1'b0;
      cyc(3);

      cmp_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
